// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS-subset core: opcodes, functs, ALU codes,
// controller states and the control bundle passed from controller to datapath.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam int unsigned STATE_W = 4;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_ADDIEX = 4'd8;
   localparam logic [3:0] S_ADDIWB = 4'd9;
   localparam logic [3:0] S_BRANCH = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;
   localparam logic [3:0] S_HALT   = 4'd12;

   typedef enum logic [1:0] {
      WB_NONE   = 2'd0,
      WB_RT_MDR = 2'd1,
      WB_RD_ALU = 2'd2,
      WB_RT_ALU = 2'd3
   } wb_sel_e;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       addr_alu;
      logic       ir_we;
      logic       ab_we;
      logic       adr_we;
      logic       mdr_we;
      logic       exec_we;
      logic       addi_we;
      wb_sel_e    wb_sel;
      logic       branch;
      logic       jump;
      logic       retire;
      logic       halted;
      logic [2:0] alu_ctrl;
   } ctrl_t;

endpackage

// File: rtl/mips_mc_controller.sv
// Multicycle controller: registered state plus Moore/handshake-decoded datapath controls.
import mips_pkg::*;

module mips_mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   input  logic       mem_ready_i,
   output ctrl_t      ctrl_o
);

   logic [STATE_W-1:0] state_q, state_d;
   logic               funct_ok;
   logic [2:0]         funct_alu;

   always_comb begin
      funct_ok  = 1'b1;
      funct_alu = ALU_ADD;
      case (funct_i)
         FN_ADD:  funct_alu = ALU_ADD;
         FN_SUB:  funct_alu = ALU_SUB;
         FN_AND:  funct_alu = ALU_AND;
         FN_OR:   funct_alu = ALU_OR;
         FN_SLT:  funct_alu = ALU_SLT;
         default: funct_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Controls are forced inactive while reset is high so a pending access is dropped at once.
   always_comb begin
      state_d         = state_q;
      ctrl_o          = '0;
      ctrl_o.wb_sel   = WB_NONE;
      ctrl_o.alu_ctrl = ALU_ADD;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               ctrl_o.mem_req = 1'b1;
               if (mem_ready_i) begin
                  ctrl_o.ir_we = 1'b1;
                  state_d      = S_DECODE;
               end
            end
            S_DECODE: begin
               ctrl_o.ab_we = 1'b1;
               case (opcode_i)
                  OP_LW, OP_SW: state_d = S_MEMADR;
                  OP_RTYPE:     state_d = S_EXEC;
                  OP_ADDI:      state_d = S_ADDIEX;
                  OP_BEQ:       state_d = S_BRANCH;
                  OP_J:         state_d = S_JUMP;
                  default:      state_d = S_HALT;
               endcase
            end
            S_MEMADR: begin
               ctrl_o.adr_we = 1'b1;
               state_d       = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               ctrl_o.mem_req  = 1'b1;
               ctrl_o.addr_alu = 1'b1;
               if (mem_ready_i) begin
                  ctrl_o.mdr_we = 1'b1;
                  state_d       = S_MEMWB;
               end
            end
            S_MEMWB: begin
               ctrl_o.wb_sel = WB_RT_MDR;
               ctrl_o.retire = 1'b1;
               state_d       = S_FETCH;
            end
            S_MEMWR: begin
               ctrl_o.mem_req  = 1'b1;
               ctrl_o.mem_we   = 1'b1;
               ctrl_o.addr_alu = 1'b1;
               if (mem_ready_i) begin
                  ctrl_o.retire = 1'b1;
                  state_d       = S_FETCH;
               end
            end
            S_EXEC: begin
               ctrl_o.alu_ctrl = funct_alu;
               if (funct_ok) begin
                  ctrl_o.exec_we = 1'b1;
                  state_d        = S_ALUWB;
               end else begin
                  state_d = S_HALT;
               end
            end
            S_ALUWB: begin
               ctrl_o.wb_sel = WB_RD_ALU;
               ctrl_o.retire = 1'b1;
               state_d       = S_FETCH;
            end
            S_ADDIEX: begin
               ctrl_o.addi_we = 1'b1;
               state_d        = S_ADDIWB;
            end
            S_ADDIWB: begin
               ctrl_o.wb_sel = WB_RT_ALU;
               ctrl_o.retire = 1'b1;
               state_d       = S_FETCH;
            end
            S_BRANCH: begin
               ctrl_o.branch = 1'b1;
               ctrl_o.retire = 1'b1;
               state_d       = S_FETCH;
            end
            S_JUMP: begin
               ctrl_o.jump   = 1'b1;
               ctrl_o.retire = 1'b1;
               state_d       = S_FETCH;
            end
            S_HALT:  ctrl_o.halted = 1'b1;
            default: state_d = S_HALT;
         endcase
      end
   end

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS-subset core datapath: pc, IR, MDR, A/B, ALUOut, register file and shared ALU.
import mips_pkg::*;

module mips_multicycle #(
   parameter int unsigned      WIDTH          = 32,
   parameter int unsigned      INST_WIDTH     = 32,
   parameter int unsigned      REG_COUNT_BITS = 5,
   parameter logic [WIDTH-1:0] RESET_PC       = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] mem_addr,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
   output logic [WIDTH-1:0] pc,
   output logic             retire,
   output logic             halted
);

   localparam int unsigned REG_COUNT = 1 << REG_COUNT_BITS;

   ctrl_t                     ctrl;
   logic [WIDTH-1:0]          pc_q, pc_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
   logic [INST_WIDTH-1:0]     ir_q, ir_d;
   logic [WIDTH-1:0]          rf_q [REG_COUNT];
   logic [REG_COUNT_BITS-1:0] rs, rt, rd, wa;
   logic                      rf_we;
   logic [WIDTH-1:0]          wd, imm_sx, src_b, alu_res;

   mips_mc_controller u_ctrl (
      .clk         (clk),
      .reset       (reset),
      .opcode_i    (ir_q[31:26]),
      .funct_i     (ir_q[5:0]),
      .mem_ready_i (mem_ready),
      .ctrl_o      (ctrl)
   );

   assign rs     = REG_COUNT_BITS'(ir_q[25:21]);
   assign rt     = REG_COUNT_BITS'(ir_q[20:16]);
   assign rd     = REG_COUNT_BITS'(ir_q[15:11]);
   assign imm_sx = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};

   // Shared ALU: address and addi calculations substitute the immediate for B.
   assign src_b = (ctrl.adr_we || ctrl.addi_we) ? imm_sx : b_q;

   always_comb begin
      case (ctrl.alu_ctrl)
         ALU_AND: alu_res = a_q & src_b;
         ALU_OR:  alu_res = a_q | src_b;
         ALU_SUB: alu_res = a_q - src_b;
         ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(src_b))};
         default: alu_res = a_q + src_b;
      endcase
   end

   always_comb begin
      pc_d  = pc_q;
      ir_d  = ir_q;
      mdr_d = mdr_q;
      a_d   = a_q;
      b_d   = b_q;
      alu_d = alu_q;
      if (ctrl.ir_we) begin
         ir_d = INST_WIDTH'(mem_rdata);
         pc_d = pc_q + WIDTH'(4);
      end
      if (ctrl.ab_we) begin
         a_d   = rf_q[rs];
         b_d   = rf_q[rt];
         alu_d = pc_q + (imm_sx << 2);
      end
      if (ctrl.adr_we || ctrl.exec_we || ctrl.addi_we) alu_d = alu_res;
      if (ctrl.mdr_we) mdr_d = mem_rdata;
      if (ctrl.branch && (a_q == b_q)) pc_d = alu_q;
      if (ctrl.jump) pc_d = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
   end

   always_comb begin
      rf_we = 1'b0;
      wa    = rt;
      wd    = alu_q;
      case (ctrl.wb_sel)
         WB_RT_MDR: begin rf_we = 1'b1; wd = mdr_q; end
         WB_RD_ALU: begin rf_we = 1'b1; wa = rd;    end
         WB_RT_ALU: rf_we = 1'b1;
         default:   rf_we = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q  <= RESET_PC;
         ir_q  <= '0;
         mdr_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         alu_q <= '0;
         for (int unsigned i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
      end else begin
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         mdr_q <= mdr_d;
         a_q   <= a_d;
         b_q   <= b_d;
         alu_q <= alu_d;
         // r0 is never written, so it always reads as zero.
         if (rf_we && (wa != '0)) rf_q[wa] <= wd;
      end
   end

   assign mem_req   = ctrl.mem_req;
   assign mem_we    = ctrl.mem_we;
   assign mem_addr  = ctrl.addr_alu ? alu_q : pc_q;
   assign mem_wdata = b_q;
   assign pc        = pc_q;
   assign retire    = ctrl.retire;
   assign halted    = ctrl.halted;

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: memory responder with wait states plus an instruction-level reference model.
module tb_mips_multicycle;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] mem_addr, mem_wdata, pc;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;
   logic        mem_req, mem_we, retire, halted;

   always #5 clk = ~clk;

   mips_multicycle dut (
      .clk       (clk),
      .reset     (reset),
      .mem_addr  (mem_addr),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc        (pc),
      .retire    (retire),
      .halted    (halted)
   );

   int          checks = 0;
   int          failures = 0;
   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];
   logic [31:0] m_rf    [32];
   logic [31:0] m_pc;
   int          cyc, last_ret, waits_acc, wcnt, cur_need, fwait, dwait;
   bit          rnd_wait, busy, st_seen, hold_we;
   logic [31:0] st_addr, st_data, hold_addr;
   logic        s_retire, s_halted, s_req;
   logic [31:0] s_pc;
   int          ret_log [$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
   endfunction

   function automatic bit is_illegal(input logic [31:0] ins);
      case (ins[31:26])
         6'h00:                      return !(ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
         6'h02, 6'h04, 6'h08, 6'h23, 6'h2B: return 1'b0;
         default:                    return 1'b1;
      endcase
   endfunction

   // One clock: answer the memory port at the falling edge, then sample outputs.
   task automatic tick();
      #1;
      if (mem_req === 1'b1) begin
         if (!busy) begin
            busy      = 1'b1;
            wcnt      = 0;
            hold_addr = mem_addr;
            hold_we   = mem_we;
            if (rnd_wait) cur_need = int'($urandom_range(0, 2));
            else          cur_need = (!mem_we && mem_addr == pc) ? fwait : dwait;
         end else begin
            chk("hold_addr", mem_addr, hold_addr);
            chk("hold_we", 32'(mem_we), 32'(hold_we));
         end
         if (wcnt < cur_need) begin
            mem_ready = 1'b0;
            wcnt++;
            waits_acc++;
         end else begin
            mem_ready = 1'b1;
            busy      = 1'b0;
            if (mem_we) begin
               mem[mem_addr[9:2]] = mem_wdata;
               st_seen = 1'b1;
               st_addr = mem_addr;
               st_data = mem_wdata;
            end else begin
               mem_rdata = mem[mem_addr[9:2]];
            end
         end
      end else begin
         mem_ready = 1'b0;
         busy      = 1'b0;
      end
      #1;
      s_retire = retire;
      s_halted = halted;
      s_req    = mem_req;
      s_pc     = pc;
      cyc++;
      @(negedge clk);
   endtask

   task automatic wr_reg(input logic [4:0] r, input logic [31:0] v);
      if (r != 5'd0) m_rf[r] = v;
   endtask

   // Instruction-level reference: executes the instruction at m_pc, returns its base cycle count.
   task automatic model_step(output int base, output bit is_st, output logic [31:0] sa, output logic [31:0] sd);
      logic [31:0] ins, a, b, sx, npc, res;
      logic [4:0]  rs, rt, rd;
      ins = ref_mem[m_pc[9:2]];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      a = m_rf[rs]; b = m_rf[rt];
      sx = {{16{ins[15]}}, ins[15:0]};
      npc = m_pc + 32'd4;
      is_st = 1'b0; sa = '0; sd = '0; base = 4;
      case (ins[31:26])
         6'h08: wr_reg(rt, a + sx);
         6'h00: begin
            case (ins[5:0])
               6'h20:   res = a + b;
               6'h22:   res = a - b;
               6'h24:   res = a & b;
               6'h25:   res = a | b;
               default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            endcase
            wr_reg(rd, res);
         end
         6'h23: begin base = 5; sa = a + sx; wr_reg(rt, ref_mem[sa[9:2]]); end
         6'h2B: begin is_st = 1'b1; sa = a + sx; sd = b; ref_mem[sa[9:2]] = b; end
         6'h04: begin base = 3; if (a == b) npc = npc + (sx << 2); end
         default: begin base = 3; npc = {npc[31:28], ins[25:0], 2'b00}; end
      endcase
      m_pc = npc;
   endtask

   task automatic expect_halt();
      int t, nr, nq, nh;
      t = 0;
      do begin tick(); t++; end while (!s_halted && t < 12);
      chk("halt_set", 32'(s_halted), 32'd1);
      nr = 0; nq = 0; nh = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         nr += int'(s_retire);
         nq += int'(s_req);
         nh += int'(!s_halted);
      end
      chk("halt_no_retire", 32'(nr), 32'd0);
      chk("halt_no_req", 32'(nq), 32'd0);
      chk("halt_sticky", 32'(nh), 32'd0);
   endtask

   task automatic run(input int n);
      int t, base;
      bit is_st;
      logic [31:0] sa, sd;
      for (int k = 0; k < n; k++) begin
         if (is_illegal(ref_mem[m_pc[9:2]])) begin
            expect_halt();
            return;
         end
         t = 0;
         do begin tick(); t++; end while (!s_retire && t < 60);
         if (!s_retire) begin
            chk("retire_timeout", 32'd0, 32'd1);
            return;
         end
         ret_log.push_back(cyc);
         model_step(base, is_st, sa, sd);
         chk("cpi", 32'(cyc - last_ret), 32'(base + waits_acc));
         last_ret  = cyc;
         waits_acc = 0;
         chk("store_seen", 32'(st_seen), 32'(is_st));
         if (is_st && st_seen) begin
            chk("store_addr", st_addr, sa);
            chk("store_data", st_data, sd);
         end
         st_seen = 1'b0;
         tick();
         chk("pc", s_pc, m_pc);
         chk("retire_pulse", 32'(s_retire), 32'd0);
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      mem_ready = 1'b0;
      tick();
      tick();
      chk("rst_pc", s_pc, 32'h0);
      chk("rst_req", 32'(s_req), 32'd0);
      chk("rst_retire", 32'(s_retire), 32'd0);
      chk("rst_halted", 32'(s_halted), 32'd0);
      chk("rst_no_store", 32'(st_seen), 32'd0);
      reset     = 1'b0;
      cyc       = 0;
      last_ret  = 0;
      waits_acc = 0;
      busy      = 1'b0;
      st_seen   = 1'b0;
      ret_log.delete();
      m_pc = 32'h0;
      for (int i = 0; i < 32; i++)  m_rf[i] = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
   endtask

   initial begin
      logic [5:0] fns [5];
      int         n, t, r, off;
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
      st_seen = 1'b0;
      rnd_wait = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;

      // Directed program: addi/add timing, slt, r0, j, sw/lw with data wait states, beq loop.
      fwait = 0; dwait = 2;
      mem[0]  = enc_i(6'h08, 0, 1, 16'd5);
      mem[1]  = enc_i(6'h08, 0, 2, 16'hFFFD);
      mem[2]  = enc_r(1, 2, 3, 6'h20);
      mem[3]  = enc_r(2, 1, 5, 6'h2A);
      mem[4]  = enc_r(1, 1, 0, 6'h20);
      mem[5]  = enc_i(6'h2B, 0, 5, 16'h0200);
      mem[6]  = enc_i(6'h2B, 0, 0, 16'h0204);
      mem[7]  = enc_i(6'h2B, 0, 3, 16'h0208);
      mem[8]  = {6'h02, 26'h40};
      mem[64] = enc_i(6'h2B, 0, 3, 16'h0008);
      mem[65] = enc_i(6'h23, 0, 4, 16'h0008);
      mem[66] = enc_i(6'h2B, 0, 4, 16'h020C);
      mem[67] = enc_i(6'h04, 1, 1, 16'hFFFF);
      do_reset();
      run(3);
      chk("ret_cycle0", 32'(ret_log[0]), 32'd4);
      chk("ret_cycle1", 32'(ret_log[1]), 32'd8);
      chk("ret_cycle2", 32'(ret_log[2]), 32'd12);
      run(6);
      chk("j_pc", s_pc, 32'h100);
      run(2);
      chk("lw_cycles", 32'(ret_log[10] - ret_log[9]), 32'd7);
      chk("sw8_data", mem[2], 32'd2);
      run(5);
      chk("slt_r5", mem[128], 32'd1);
      chk("r0_zero", mem[129], 32'd0);
      chk("add_r3", mem[130], 32'd2);
      chk("lw_r4", mem[131], 32'd2);
      chk("beq_pc", s_pc, 32'h10C);

      // Illegal opcode, then illegal funct.
      mem[0] = 32'hFC00_0000;
      do_reset();
      run(1);
      mem[0] = enc_r(1, 1, 1, 6'h3F);
      do_reset();
      run(1);

      // Reset in the middle of a stalled store.
      fwait = 0; dwait = 6;
      mem[0] = enc_i(6'h08, 0, 1, 16'd7);
      mem[1] = enc_i(6'h2B, 0, 1, 16'h0200);
      mem[128] = 32'hFFFF_FFFF;
      do_reset();
      run(1);
      t = 0;
      do begin tick(); t++; end while (!(s_req && mem_we) && t < 10);
      chk("memwr_reached", 32'(s_req && mem_we), 32'd1);
      tick();
      tick();
      mem[0] = enc_i(6'h2B, 0, 1, 16'h0204);
      mem[1] = 32'hFC00_0000;
      mem[129] = 32'hFFFF_FFFF;
      do_reset();
      chk("abandoned_store", mem[128], 32'hFFFF_FFFF);
      dwait = 0;
      run(2);
      chk("r1_not_written", mem[129], 32'd0);

      // Random program with random wait states, register dump, then halt.
      rnd_wait = 1'b1;
      for (int i = 128; i < 256; i++) mem[i] = $urandom;
      n = 40;
      for (int i = 0; i < n; i++) begin
         r = int'($urandom_range(0, 9));
         case (r)
            0, 1, 2, 9: mem[i] = enc_i(6'h08, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'($urandom));
            3, 4, 5:    mem[i] = enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                       int'($urandom_range(0, 7)), fns[$urandom_range(0, 4)]);
            6:          mem[i] = enc_i(6'h2B, 0, int'($urandom_range(0, 7)), 16'(32'h200 + 4 * $urandom_range(0, 63)));
            7:          mem[i] = enc_i(6'h23, 0, int'($urandom_range(0, 7)), 16'(32'h200 + 4 * $urandom_range(0, 63)));
            default: begin
               off = int'($urandom_range(0, ((n - 1 - i) < 2) ? (n - 1 - i) : 2));
               mem[i] = enc_i(6'h04, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'(off));
            end
         endcase
      end
      for (int j = 0; j < 7; j++) mem[n + j] = enc_i(6'h2B, 0, j + 1, 16'(32'h300 + 4 * j));
      mem[n + 7] = 32'hFC00_0000;
      do_reset();
      run(400);
      chk("rand_halted", 32'(s_halted), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
